audio_volume_div: RTL and testbench
===================================

Name: audio_volume_div

Overview:
- Per-channel digital attenuator between the tone generators and audio_codec; produces the codec's data_left/data_right.
- Each accepted stereo sample is divided by (2^ATT_W - att) using a single shared serial restoring divider, left channel then right channel.
- Results are registered and flagged with a one-cycle out_valid pulse.
- Throughput is far above audio sample rates, so the block sits on the 50 MHz system clock.

Parameters:
- WIDTH, 24, sample width in bits (signed two's complement); also the divider iteration count per channel.
- ATT_W, 4, attenuation code width; divisor = 2^ATT_W - att, range 1..2^ATT_W.

Ports:
- sys_clk  in  1  system clock (50 MHz); all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_left  in  WIDTH  signed left sample.
- in_right  in  WIDTH  signed right sample.
- att_left  in  ATT_W  left attenuation code (0 = divide by 16, 15 = divide by 1 at ATT_W=4).
- att_right  in  ATT_W  right attenuation code.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept a sample.
- data_left  out  WIDTH  signed attenuated left sample, registered.
- data_right  out  WIDTH  signed attenuated right sample, registered.
- out_valid  out  1  one-cycle pulse: data_left/data_right updated.

Behaviour:
- Reset values: in_ready=1, out_valid=0, data_left=0, data_right=0, FSM=IDLE, active attenuation registers=0.
- Reset asserted mid-division aborts the operation. Partial results are discarded and all outputs take their reset values immediately.
- Acceptance occurs at a rising edge with in_valid&&in_ready (edge E0). At that edge:
  - in_left, in_right, att_left and att_right are captured.
  - in_ready drops to 0.
- in_valid while in_ready=0 is ignored; no buffering.
- FSM: IDLE -> DIV_L (WIDTH cycles) -> DIV_R (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
- Divide algorithm, per channel:
  - Take the magnitude |x|. It fits WIDTH unsigned bits, including -2^(WIDTH-1).
  - Perform restoring long division, one quotient bit per cycle, MSB first.
  - Negate the quotient if x<0.
  - Result is truncation toward zero, identical to Verilog signed '/'.
  - Divisor is never 0, so no divide-by-zero case exists.
- Latency: data_left, data_right and out_valid update at edge E0+2*WIDTH+1 (E0+49 at default).
  - out_valid is high for exactly one cycle.
  - Both channels update on the same edge.
- in_ready returns to 1 at that same edge, so the earliest next accept is edge E0+2*WIDTH+2. Throughput is one sample per 2*WIDTH+2 cycles.
- Between updates, data_left/data_right hold their last values and never show intermediate divider state.
- Width rule: quotient magnitude <= |x|, so no overflow. -2^(WIDTH-1)/1 = -2^(WIDTH-1) exactly.

Optional Feature:
- Macro: AUDIO_VOLUME_ZERO_CROSS_EN.
- Defined:
  - Captured att codes go to per-channel pending registers.
  - A channel's active code is replaced by its pending code only when that channel's accepted sample is 0, or its sign differs from that channel's previous accepted sample.
  - The update takes effect for the current sample's division.
  - The previous-sign register resets to "non-negative".
  - Purpose: click-free volume changes.
- Undefined: the captured att codes are used directly for that sample's division. The pending/sign registers are not built.

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, outputs 0. Assert reset during DIV_R -> outputs 0 and in_ready=1 on reset; next accept completes normally.
- in_left=24'sd1600, in_right=-24'sd1600, att_left=0, att_right=15, accepted at E0 -> out_valid only at E0+49, data_left=100, data_right=-1600.
- Truncation: in_left=-7, att_left=14 (div 2) -> data_left=-3; in_right=7, att_right=14 -> data_right=3.
- Extremes: in_left=-8388608, att_left=15 -> -8388608; in_right=8388607, att_right=0 -> 524287.
- Handshake: in_valid held high continuously -> accepts exactly every 50 cycles. Pulses of in_valid while in_ready=0 -> ignored, no extra out_valid.
- Zero-cross (macro defined): samples +100, +100, -100 with att_left changing 0->15 before the second sample -> left outputs 6, 6, -100. Macro undefined, same stimulus -> 6, 100, -100.

Source files
------------

// File: rtl/audio_volume_div.sv
// audio_volume_div: stereo attenuator that divides each accepted sample by
// (2^ATT_W - att). One serial restoring divider is shared: the left channel
// is divided first, then the right. Both results are published together,
// together with a one-cycle out_valid pulse.
// Optional build macro: AUDIO_VOLUME_ZERO_CROSS_EN. When it is defined, a
// channel's new attenuation code is only applied on a zero crossing of that
// channel, so volume changes do not click.
module audio_volume_div #(
  parameter int WIDTH = 24,
  parameter int ATT_W = 4
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] in_left,
  input  logic signed [WIDTH-1:0] in_right,
  input  logic [ATT_W-1:0]        att_left,
  input  logic [ATT_W-1:0]        att_right,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] data_left,
  output logic signed [WIDTH-1:0] data_right,
  output logic                    out_valid
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int DIVR_W = ATT_W + 1;          // divisor reaches 2^ATT_W

  typedef enum logic [1:0] {IDLE, DIV_L, DIV_R, DONE} state_t;

  state_t              state_reg;
  logic [WIDTH-1:0]    dvd_reg;               // dividend, becomes the quotient
  logic [DIVR_W-1:0]   rem_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [WIDTH-1:0]    mag_right_reg;         // right magnitude waits here
  logic [WIDTH-1:0]    quo_left_reg;          // signed left result
  logic                neg_reg [2];           // sign of last accepted sample
  logic [ATT_W-1:0]    act_reg [2];           // active attenuation codes

  // Per-channel views of the inputs (index 0 = left, 1 = right)
  logic [WIDTH-1:0]    smp_in  [2];
  logic [ATT_W-1:0]    att_in  [2];
  logic [WIDTH-1:0]    mag_in  [2];
  logic [ATT_W-1:0]    act_next [2];

  assign smp_in[0] = in_left;
  assign smp_in[1] = in_right;
  assign att_in[0] = att_left;
  assign att_in[1] = att_right;

  // Magnitude and next active code, per channel
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      // |x| fits WIDTH unsigned bits, including the most negative value
      assign mag_in[gi] = smp_in[gi][WIDTH-1] ? (~smp_in[gi] + WIDTH'(1))
                                               : smp_in[gi];
`ifdef AUDIO_VOLUME_ZERO_CROSS_EN
      // The pending code is the one being captured; it replaces the active
      // code only on a zero sample or a sign change versus the last sample.
      logic zero_cross;
      assign zero_cross = (smp_in[gi] == '0) ||
                          (smp_in[gi][WIDTH-1] != neg_reg[gi]);
      assign act_next[gi] = zero_cross ? att_in[gi] : act_reg[gi];
`else
      assign act_next[gi] = att_in[gi];
`endif
    end
  endgenerate

  // One restoring-division step on the current channel
  logic [DIVR_W-1:0] divisor;
  logic [DIVR_W:0]   shifted;
  logic [DIVR_W:0]   trial;
  logic              qbit;
  logic [DIVR_W-1:0] rem_next;
  logic [WIDTH-1:0]  quo_next;
  logic              last_iter;

  always_comb begin
    divisor = '0;
    if (state_reg == DIV_R)
      divisor = {1'b1, {ATT_W{1'b0}}} - {1'b0, act_reg[1]};
    else
      divisor = {1'b1, {ATT_W{1'b0}}} - {1'b0, act_reg[0]};
    shifted   = {rem_reg, dvd_reg[WIDTH-1]};
    trial     = shifted - {1'b0, divisor};
    qbit      = ~trial[DIVR_W];
    // A remainder below the divisor always fits DIVR_W bits
    rem_next  = qbit ? trial[DIVR_W-1:0] : shifted[DIVR_W-1:0];
    quo_next  = {dvd_reg[WIDTH-2:0], qbit};
    last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
  end

  // Handshake, sequencing of the shared divider and output registers
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      dvd_reg       <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      mag_right_reg <= '0;
      quo_left_reg  <= '0;
      neg_reg[0]    <= 1'b0;
      neg_reg[1]    <= 1'b0;
      act_reg[0]    <= '0;
      act_reg[1]    <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      data_left     <= '0;
      data_right    <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            neg_reg[0]    <= in_left[WIDTH-1];
            neg_reg[1]    <= in_right[WIDTH-1];
            act_reg[0]    <= act_next[0];
            act_reg[1]    <= act_next[1];
            dvd_reg       <= mag_in[0];
            mag_right_reg <= mag_in[1];
            rem_reg       <= '0;
            cnt_reg       <= '0;
            in_ready      <= 1'b0;
            state_reg     <= DIV_L;
          end
        end
        DIV_L: begin
          if (last_iter) begin
            quo_left_reg <= neg_reg[0] ? -quo_next : quo_next;
            dvd_reg      <= mag_right_reg;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            state_reg    <= DIV_R;
          end else begin
            dvd_reg <= quo_next;
            rem_reg <= rem_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DIV_R: begin
          dvd_reg <= quo_next;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (last_iter)
            state_reg <= DONE;
        end
        DONE: begin
          // dvd_reg now holds the unsigned right quotient
          data_left  <= quo_left_reg;
          data_right <= neg_reg[1] ? -dvd_reg : dvd_reg;
          out_valid  <= 1'b1;
          in_ready   <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_volume_div.sv
// Directed bench for audio_volume_div with hand-computed expected values.
module tb_audio_volume_div;

  localparam int WIDTH = 24;
  localparam int ATT_W = 4;

  logic                    sys_clk = 1'b0;
  logic                    reset;
  logic signed [WIDTH-1:0] in_left;
  logic signed [WIDTH-1:0] in_right;
  logic [ATT_W-1:0]        att_left;
  logic [ATT_W-1:0]        att_right;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] data_left;
  logic signed [WIDTH-1:0] data_right;
  logic                    out_valid;

  int checks = 0;
  int errors = 0;

  audio_volume_div #(.WIDTH(WIDTH), .ATT_W(ATT_W)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .in_left    (in_left),
    .in_right   (in_right),
    .att_left   (att_left),
    .att_right  (att_right),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_left  (data_left),
    .data_right (data_right),
    .out_valid  (out_valid)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) check("ready_timeout", 32'(in_ready), 1);
  endtask

  // Accept one sample, watch 60 cycles, check latency, pulse count and data
  task automatic run_sample(input string tag,
                            input logic signed [WIDTH-1:0] l,
                            input logic signed [WIDTH-1:0] r,
                            input logic [ATT_W-1:0] al,
                            input logic [ATT_W-1:0] ar,
                            input logic signed [WIDTH-1:0] el,
                            input logic signed [WIDTH-1:0] er);
    int lat = 0;
    int pulses = 0;
    logic signed [WIDTH-1:0] gl = '0;
    logic signed [WIDTH-1:0] gr = '0;
    wait_ready();
    in_left = l; in_right = r; att_left = al; att_right = ar;
    in_valid = 1'b1;
    tick();                      // accept edge E0
    in_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (out_valid === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat = k; gl = data_left; gr = data_right;
        end
      end
    end
    check({tag, "_latency"}, lat, 49);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_left"}, gl, el);
    check({tag, "_right"}, gr, er);
    check({tag, "_ready"}, 32'(in_ready), 1);
    $display("sample %s: in=(%0d,%0d) att=(%0d,%0d) out=(%0d,%0d) latency=%0d",
             tag, l, r, al, ar, gl, gr, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_acc;
    int n_out;
    int acc [3];
    int pulses;
    int cnt;
    logic signed [WIDTH-1:0] gl;
    logic signed [WIDTH-1:0] gr;

    reset = 1'b1; in_valid = 1'b0;
    in_left = '0; in_right = '0; att_left = '0; att_right = '0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(in_ready), 1);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_left", data_left, 0);
    check("rst_right", data_right, 0);

    run_sample("basic", 24'sd1600, -24'sd1600, 4'd0, 4'd15, 24'sd100, -24'sd1600);
    run_sample("trunc", -24'sd7, 24'sd7, 4'd14, 4'd14, -24'sd3, 24'sd3);

    // Reset during the right-channel division aborts the operation
    wait_ready();
    in_left = 24'sd1600; in_right = 24'sd1600; att_left = 4'd0; att_right = 4'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    reset = 1'b1;
    #1;
    check("midrst_left", data_left, 0);
    check("midrst_right", data_right, 0);
    check("midrst_ready", 32'(in_ready), 1);
    check("midrst_valid", 32'(out_valid), 0);
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (out_valid === 1'b1) cnt++;
    end
    check("midrst_no_output", cnt, 0);
    $display("reset during DIV_R: outputs cleared, stray pulses=%0d", cnt);

    run_sample("extreme", 24'sh800000, 24'sd8388607, 4'd15, 4'd0,
               24'sh800000, 24'sd524287);

    // in_valid held high: one accept every 50 cycles
    do_reset();
    in_left = 24'sd1600; in_right = -24'sd1600; att_left = 4'd0; att_right = 4'd15;
    in_valid = 1'b1;
    n_acc = 0; n_out = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    for (int c = 0; c < 150; c++) begin
      if (in_ready === 1'b1) begin
        if (n_acc < 3) acc[n_acc] = c + 1;
        n_acc++;
      end
      tick();
      if (out_valid === 1'b1) begin
        n_out++;
        check("stream_left", data_left, 100);
        check("stream_right", data_right, -1600);
      end
    end
    in_valid = 1'b0;
    check("stream_accepts", n_acc, 3);
    check("stream_outputs", n_out, 3);
    check("stream_gap1", acc[1] - acc[0], 50);
    check("stream_gap2", acc[2] - acc[1], 50);
    $display("stream: accepts=%0d outputs=%0d accept edges %0d %0d %0d",
             n_acc, n_out, acc[0], acc[1], acc[2]);

    // in_valid pulses while busy are ignored
    do_reset();
    wait_ready();
    in_left = -24'sd1000; in_right = -24'sd1000; att_left = 4'd6; att_right = 4'd6;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    pulses = 0; gl = '0; gr = '0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (out_valid === 1'b1) begin
        pulses++; gl = data_left; gr = data_right;
      end
      if (k == 5 || k == 17 || k == 40) begin
        in_left = 24'sd5000; in_right = 24'sd5000; att_left = 4'd15; att_right = 4'd15;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_left", gl, -100);
    check("ignore_right", gr, -100);
    $display("busy pulses: out_valid count=%0d out=(%0d,%0d)", pulses, gl, gr);

    // Attenuation change on left between two positive samples
    do_reset();
    run_sample("zc1", 24'sd100, 24'sd0, 4'd0, 4'd15, 24'sd6, 24'sd0);
`ifdef AUDIO_VOLUME_ZERO_CROSS_EN
    run_sample("zc2", 24'sd100, 24'sd0, 4'd15, 4'd15, 24'sd6, 24'sd0);
`else
    run_sample("zc2", 24'sd100, 24'sd0, 4'd15, 4'd15, 24'sd100, 24'sd0);
`endif
    run_sample("zc3", -24'sd100, 24'sd0, 4'd15, 4'd15, -24'sd100, 24'sd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
